// File: rtl/and_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// and_arb_pkg
// Shared types and helpers for the and_arbiter block.
//   arb_state_t : sequencer states (IDLE -> EXEC -> CAPT -> RESP -> IDLE)
//   id_width()  : bits needed to hold a requester index 0..n-1 (minimum 1)
// -----------------------------------------------------------------------------
package and_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Index width for a requester population of n; never narrower than 1 bit.
  function automatic int id_width(input int n);
    int v_w;
    if (n <= 2) begin
      v_w = 1;
    end else begin
      v_w = $clog2(n);
    end
    return v_w;
  endfunction

endpackage

// File: rtl/and_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Scans i_req starting at i_ptr,
// wrapping modulo G_N, and returns the first set bit.
//   i_req   in  G_N    request vector
//   i_ptr   in  G_IDW  index where the scan starts
//   o_gnt   out G_N    one-hot grant (all zero when no request)
//   o_idx   out G_IDW  index of the granted requester (0 when none)
//   o_any   out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import and_arb_pkg::*;
#(
  parameter int G_N   = 4,
  parameter int G_IDW = 2
) (
  input  logic [G_N-1:0]   i_req,
  input  logic [G_IDW-1:0] i_ptr,
  output logic [G_N-1:0]   o_gnt,
  output logic [G_IDW-1:0] o_idx,
  output logic             o_any
);

  logic [G_N-1:0]   w_gnt;
  logic [G_IDW-1:0] w_idx;
  logic             w_found;

  // Scan offsets 0..G_N-1 from the pointer; the first hit wins.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < G_N; k++) begin
      for (int j = 0; j < G_N; j++) begin
        if (((int'(i_ptr) + k) % G_N == j) && i_req[j] && !w_found) begin
          w_found  = 1'b1;
          w_gnt[j] = 1'b1;
          w_idx    = j[G_IDW-1:0];
        end else begin
          w_found = w_found;
        end
      end
    end
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;
  assign o_any = w_found;

endmodule

// File: rtl/and_arbiter.sv
// -----------------------------------------------------------------------------
// and_arbiter
// Round-robin arbiter/sequencer sharing one external combinational AND unit
// (and1) between G_NUM_REQ requesters. One transaction at a time:
// accept (IDLE) -> EXEC (and1 settles) -> CAPT (result registered) ->
// RESP (held until the granted requester accepts it).
//   clk, rst    single clock, synchronous active-high reset
//   req_valid   in  per-requester request valid
//   req_ready   out per-requester accept (combinational, IDLE only, one-hot)
//   req_a/req_b in  packed operands, requester i at [i*G_WIDTH +: G_WIDTH]
//   rsp_valid   out per-requester response valid (one-hot)
//   rsp_ready   in  per-requester response accept
//   rsp_c       out shared result bus
//   op_a/op_b   out registered operands to and1
//   op_c        in  result from and1
//   busy        out high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module and_arbiter
  import and_arb_pkg::*;
#(
  parameter int G_WIDTH   = 8,
  parameter int G_NUM_REQ = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [G_NUM_REQ-1:0]           req_valid,
  output logic [G_NUM_REQ-1:0]           req_ready,
  input  logic [G_NUM_REQ*G_WIDTH-1:0]   req_a,
  input  logic [G_NUM_REQ*G_WIDTH-1:0]   req_b,
  output logic [G_NUM_REQ-1:0]           rsp_valid,
  input  logic [G_NUM_REQ-1:0]           rsp_ready,
  output logic [G_WIDTH-1:0]             rsp_c,
  output logic [G_WIDTH-1:0]             op_a,
  output logic [G_WIDTH-1:0]             op_b,
  input  logic [G_WIDTH-1:0]             op_c,
  output logic                           busy
);

  localparam int LP_IDW = id_width(G_NUM_REQ);

  arb_state_t             r_state;
  logic [LP_IDW-1:0]      r_rr_ptr;
  logic [LP_IDW-1:0]      r_gnt_idx;
  logic [G_WIDTH-1:0]     r_op_a;
  logic [G_WIDTH-1:0]     r_op_b;
  logic [G_WIDTH-1:0]     r_rsp_c;
  logic [G_NUM_REQ-1:0]   r_rsp_valid;

  arb_state_t             w_state_nxt;
  logic [G_NUM_REQ-1:0]   w_pick_gnt;
  logic [LP_IDW-1:0]      w_pick_idx;
  logic                   w_pick_any;
  logic                   w_accept;
  logic                   w_rsp_take;
  logic [G_WIDTH-1:0]     w_sel_a;
  logic [G_WIDTH-1:0]     w_sel_b;
  logic [G_NUM_REQ-1:0]   w_gnt_dec;

  rr_pick #(
    .G_N   (G_NUM_REQ),
    .G_IDW (LP_IDW)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Accept is only offered in IDLE, and never while reset is being applied.
  assign w_accept  = (r_state == IDLE) && w_pick_any && !rst;
  assign req_ready = w_accept ? w_pick_gnt : '0;

  // Only the granted requester's rsp_ready can complete the response.
  assign w_rsp_take = rsp_ready[r_gnt_idx];

  // AND-OR mux of the winner's operand slices (grant is one-hot).
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < G_NUM_REQ; i++) begin
      w_sel_a = w_sel_a | (req_a[i*G_WIDTH +: G_WIDTH] & {G_WIDTH{w_pick_gnt[i]}});
      w_sel_b = w_sel_b | (req_b[i*G_WIDTH +: G_WIDTH] & {G_WIDTH{w_pick_gnt[i]}});
    end
  end

  // Decode the stored grant index into a one-hot response mask.
  always_comb begin
    w_gnt_dec = '0;
    for (int i = 0; i < G_NUM_REQ; i++) begin
      w_gnt_dec[i] = (r_gnt_idx == i[LP_IDW-1:0]);
    end
  end

  // Next-state logic for the accept/execute/capture/respond sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = EXEC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXEC: w_state_nxt = CAPT;
      CAPT: w_state_nxt = RESP;
      RESP: begin
        if (w_rsp_take) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, grant, pointer, operand and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_c     <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a    <= w_sel_a;
        r_op_b    <= w_sel_b;
        r_gnt_idx <= w_pick_idx;
        // Pointer moves just past the winner, wrapping to 0.
        if (w_pick_idx == LP_IDW'(G_NUM_REQ - 1)) begin
          r_rr_ptr <= '0;
        end else begin
          r_rr_ptr <= w_pick_idx + LP_IDW'(1);
        end
      end
      if (r_state == CAPT) begin
        r_rsp_c <= op_c;
      end
      r_rsp_valid <= (w_state_nxt == RESP) ? w_gnt_dec : '0;
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign rsp_c     = r_rsp_c;
  assign rsp_valid = r_rsp_valid;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_and_arbiter.sv
module tb_and_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int QD = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '1;
  logic [W-1:0]    rsp_c;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    op_c;
  logic            busy;

  always #5 clk = ~clk;

  // stand-in for the shared and1 instance
  assign op_c = op_a & op_b;

  and_arbiter #(.G_WIDTH(W), .G_NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // per-requester pending requests and expected-result scoreboards
  logic [W-1:0] pa [N][QD];
  logic [W-1:0] pb [N][QD];
  int qh [N];
  int qt [N];
  logic [W-1:0] sb [N][QD];
  int sh [N];
  int st [N];

  int acc_id[$];
  int acc_cyc[$];
  int rsp_id[$];
  int rsp_cyc[$];
  logic [W-1:0] rsp_dat[$];

  task automatic push(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    pa[r][qt[r]] = a;
    pb[r][qt[r]] = b;
    qt[r]++;
  endtask

  // requester agents: observe handshakes at the edge, then present the next request
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
          sb[i][st[i]] = pa[i][qh[i]] & pb[i][qh[i]];
          st[i]++;
          qh[i]++;
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_id.push_back(i);
          rsp_cyc.push_back(cyc);
          rsp_dat.push_back(rsp_c);
          chk("rsp_outstanding", 32'(st[i] > sh[i]), 32'd1);
          if (st[i] > sh[i]) begin
            chk("scoreboard", rsp_c, sb[i][sh[i]]);
            sh[i]++;
          end
        end
      end
    end else begin
      for (int i = 0; i < N; i++) sh[i] = st[i];
    end
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (qh[i] < qt[i]);
      req_a[i*W +: W] = req_valid[i] ? pa[i][qh[i]] : 8'h00;
      req_b[i*W +: W] = req_valid[i] ? pb[i][qh[i]] : 8'h00;
    end
  end

  // behavioural model: idle / cycles-since-accept, pointer as an integer
  int m_phase = 0;
  int m_ptr   = 0;
  int m_gnt   = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_c = '0;

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_gnt = 0;
      m_a = '0; m_b = '0; m_c = '0;
    end else begin
      case (m_phase)
        0: begin
          w = winner(req_valid, m_ptr);
          if (w >= 0) begin
            m_a = req_a[w*W +: W];
            m_b = req_b[w*W +: W];
            m_gnt = w;
            m_ptr = (w + 1) % N;
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        2: begin
          m_c = m_a & m_b;
          m_phase = 3;
        end
        3: if (rsp_ready[m_gnt]) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // compare process: every non-reset cycle, on the falling edge
  always @(negedge clk) begin
    int w;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rv;
    if (!rst) begin
      w = winner(req_valid, m_ptr);
      for (int i = 0; i < N; i++) begin
        e_rdy[i] = (m_phase == 0) && (w == i);
        e_rv[i]  = (m_phase == 3) && (m_gnt == i);
      end
      chk("req_ready", req_ready, e_rdy);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_c", rsp_c, m_c);
      chk("op_a", op_a, m_a);
      chk("op_b", op_b, m_b);
      chk("busy", busy, 32'(m_phase != 0));
    end
  end

  function automatic bit drained();
    bit d;
    d = !busy && (m_phase == 0);
    for (int i = 0; i < N; i++) d = d && (qh[i] == qt[i]) && (sh[i] == st[i]);
    return d;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (n < budget && !drained()) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ab;
    int rb;
    int n;
    logic [W-1:0] exp_fd [6];
    int exp_fo [6];

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_c", rsp_c, 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_busy", busy, 32'd0);

    // fairness: all four valid from pointer 0
    ab = acc_id.size(); rb = rsp_id.size();
    exp_fo = '{0, 1, 2, 3, 0, 1};
    exp_fd = '{8'hA1, 8'h3C, 8'h81, 8'h66, 8'h12, 8'h64};
    push(0, 8'hA5, 8'hF3); push(1, 8'h3C, 8'hFF); push(2, 8'h81, 8'hC1);
    push(3, 8'h7E, 8'h66); push(0, 8'h12, 8'h1F); push(1, 8'hE7, 8'h7C);
    wait_drain(200);
    chk("fair_accepts", acc_id.size() - ab, 32'd6);
    if (acc_id.size() - ab == 6 && rsp_id.size() - rb == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("fair_order", acc_id[ab+k], exp_fo[k]);
        chk("fair_data", rsp_dat[rb+k], exp_fd[k]);
        if (k > 0) chk("fair_spacing", acc_cyc[ab+k] - acc_cyc[ab+k-1], 32'd4);
      end
    end

    // single request from 2
    ab = acc_id.size(); rb = rsp_id.size();
    push(2, 8'hF0, 8'h3C);
    wait_drain(50);
    chk("single_count", rsp_id.size() - rb, 32'd1);
    if (rsp_id.size() > rb && acc_id.size() > ab) begin
      chk("single_id", acc_id[ab], 32'd2);
      chk("single_rsp_id", rsp_id[rb], 32'd2);
      chk("single_c", rsp_dat[rb], 32'h30);
      chk("single_latency", rsp_cyc[rb] - acc_cyc[ab], 32'd3);
    end

    // pointer wrap: ptr is 3, requesters 0 and 3 arrive together
    ab = acc_id.size(); rb = rsp_id.size();
    push(0, 8'h55, 8'h0F); push(3, 8'hC3, 8'hF0);
    wait_drain(50);
    if (acc_id.size() - ab == 2 && rsp_id.size() - rb == 2) begin
      chk("wrap_first", acc_id[ab], 32'd3);
      chk("wrap_second", acc_id[ab+1], 32'd0);
      chk("wrap_c3", rsp_dat[rb], 32'hC0);
      chk("wrap_c0", rsp_dat[rb+1], 32'h05);
    end else begin
      chk("wrap_accepts", acc_id.size() - ab, 32'd2);
    end

    // backpressure on requester 1 while requester 0 waits
    rsp_ready[1] = 1'b0;
    ab = acc_id.size(); rb = rsp_id.size();
    push(1, 8'h9C, 8'hF6);
    n = 0;
    while (n < 20 && !rsp_valid[1]) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 32'(n < 20), 32'd1);
    push(0, 8'h6B, 8'h3E);
    repeat (10) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 32'b0010);
      chk("bp_rsp_c", rsp_c, 32'h94);
      chk("bp_req_ready", req_ready, 32'd0);
    end
    rsp_ready[1] = 1'b1;
    wait_drain(50);
    if (acc_id.size() - ab == 2 && rsp_id.size() - rb == 2) begin
      chk("bp_order", acc_id[ab+1], 32'd0);
      chk("bp_next_accept", acc_cyc[ab+1], rsp_cyc[rb] + 1);
      chk("bp_c0", rsp_dat[rb+1], 32'h2A);
    end else begin
      chk("bp_accepts", acc_id.size() - ab, 32'd2);
    end

    // reset while in CAPT; the in-flight op is dropped
    push(2, 8'hDE, 8'hAD);
    n = 0;
    while (n < 20 && m_phase != 2) begin
      @(negedge clk);
      n++;
    end
    chk("capt_reached", 32'(n < 20), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rb = rsp_id.size();
    @(negedge clk);
    chk("mrst_req_ready", req_ready, 32'd0);
    chk("mrst_rsp_valid", rsp_valid, 32'd0);
    chk("mrst_rsp_c", rsp_c, 32'd0);
    chk("mrst_op_a", op_a, 32'd0);
    chk("mrst_op_b", op_b, 32'd0);
    chk("mrst_busy", busy, 32'd0);
    repeat (5) @(negedge clk);
    chk("mrst_dropped", rsp_id.size() - rb, 32'd0);
    ab = acc_id.size(); rb = rsp_id.size();
    push(0, 8'hB7, 8'h5D); push(3, 8'hF9, 8'h8F);
    wait_drain(50);
    if (acc_id.size() - ab == 2 && rsp_id.size() - rb == 2) begin
      chk("mrst_ptr0_first", acc_id[ab], 32'd0);
      chk("mrst_c0", rsp_dat[rb], 32'h15);
      chk("mrst_c3", rsp_dat[rb+1], 32'h89);
    end else begin
      chk("mrst_accepts", acc_id.size() - ab, 32'd2);
    end

    // randomized sweep
    rb = rsp_id.size();
    for (int t = 0; t < 50; t++) begin
      push($urandom_range(0, N-1), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        rsp_ready = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    rsp_ready = '1;
    wait_drain(3000);
    chk("rand_count", rsp_id.size() - rb, 32'd50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
